// File: rtl/attempt_lockout_ctrl.sv
// attempt_lockout_ctrl: failed-attempt guard with timed, escalating keypad lockout
// Ports: clk; rst (async, active-low); tick (timebase strobe); mode (1 = setup, attempts ignored);
//   enter (debounced key level, rising edge = attempt); pass_ok (comparator result at the edge);
//   fail_cnt (consecutive failures); led (severity colour); locked (keypad disabled);
//   lock_remain (ticks left in lockout); lock_level (escalation for next lockout);
//   unlock_pulse (one cycle when a lockout expires).
module attempt_lockout_ctrl #(
    parameter int MAX_TRIES  = 3,
    parameter int LOCK_TICKS = 30,
    parameter int MAX_LEVEL  = 2,
    localparam int CNT_W = $clog2(MAX_TRIES + 1),
    localparam int LVL_W = (MAX_LEVEL < 1) ? 1 : $clog2(MAX_LEVEL + 1),
    localparam int TW    = $clog2((LOCK_TICKS << MAX_LEVEL) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             mode,
    input  logic             enter,
    input  logic             pass_ok,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [2:0]       led,
    output logic             locked,
    output logic [TW-1:0]    lock_remain,
    output logic [LVL_W-1:0] lock_level,
    output logic             unlock_pulse
);
    typedef enum logic {ARMED, LOCKED} state_t;

    state_t           state, nxt_state;
    logic             enter_q;
    logic             attempt;
    logic [CNT_W-1:0] nxt_fail;
    logic             nxt_locked;
    logic [TW-1:0]    nxt_remain;
    logic [LVL_W-1:0] nxt_level;
    logic             nxt_pulse;
    logic [2:0]       nxt_led;

    assign attempt = enter & ~enter_q & ~mode;

    always_comb begin
        nxt_state  = state;
        nxt_fail   = fail_cnt;
        nxt_locked = locked;
        nxt_remain = lock_remain;
        nxt_level  = lock_level;
        nxt_pulse  = 1'b0;
        if (state == ARMED) begin
            if (attempt && pass_ok) begin
                nxt_fail  = '0;
                nxt_level = '0;
            end else if (attempt && fail_cnt == CNT_W'(MAX_TRIES - 1)) begin
                nxt_fail   = CNT_W'(MAX_TRIES);
                nxt_locked = 1'b1;
                nxt_remain = TW'(LOCK_TICKS) << lock_level;
                nxt_level  = (lock_level == LVL_W'(MAX_LEVEL)) ? lock_level : lock_level + LVL_W'(1);
                nxt_state  = LOCKED;
            end else if (attempt) begin
                nxt_fail = fail_cnt + CNT_W'(1);
            end
        end else if (tick) begin
            // lock_remain is never 0 while LOCKED, so 1 marks the final tick
            if (lock_remain != TW'(1)) begin
                nxt_remain = lock_remain - TW'(1);
            end else begin
                nxt_remain = '0;
                nxt_locked = 1'b0;
                nxt_fail   = '0;
                nxt_pulse  = 1'b1;
                nxt_state  = ARMED;
            end
        end
        // fail_cnt==0 is tested first so MAX_TRIES=1 never yields 101
        nxt_led = nxt_locked ? 3'b111 :
                  (nxt_fail == '0) ? 3'b000 :
                  (nxt_fail == CNT_W'(MAX_TRIES - 1)) ? 3'b101 : 3'b001;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARMED;
            enter_q      <= 1'b0;
            fail_cnt     <= '0;
            led          <= 3'b000;
            locked       <= 1'b0;
            lock_remain  <= '0;
            lock_level   <= '0;
            unlock_pulse <= 1'b0;
        end else begin
            state        <= nxt_state;
            enter_q      <= enter;
            fail_cnt     <= nxt_fail;
            led          <= nxt_led;
            locked       <= nxt_locked;
            lock_remain  <= nxt_remain;
            lock_level   <= nxt_level;
            unlock_pulse <= nxt_pulse;
        end
    end
endmodule
